// File: rtl/cur_feeder_pkg.sv
// Shared types and derived-geometry helpers for the current-block feeder.
package cur_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int calc_wpl(input int frame_w);
        return frame_w / 4;
    endfunction

    function automatic int calc_wpr(input int blk_w);
        return blk_w / 4;
    endfunction

    function automatic int calc_wpb(input int blk_w, input int blk_h);
        return (blk_w / 4) * blk_h;
    endfunction

    function automatic int calc_frame_words(input int frame_w, input int frame_h);
        return (frame_w / 4) * frame_h;
    endfunction

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cur_feeder_fifo.sv
// Prefetch FIFO, DEPTH x W, head visible combinationally; push and pop may share a cycle.
// No internal protection: the feeder's issue rule keeps push off a full FIFO.
module cur_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/cur_feeder.sv
// Block-raster frame fetcher: one 32-bit word per req, one-cycle latency; reads throttle on FIFO+in-flight space.
// Build macro CUR_FEEDER_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module cur_feeder
    import cur_feeder_pkg::*;
#(
    parameter int FRAME_W    = 3840,
    parameter int FRAME_H    = 2160,
    parameter int BLK_W      = 8,
    parameter int BLK_H      = 8,
    parameter int ADDR_W     = 21,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req,
    output logic [31:0]       dout,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              block_done,
    output logic              frame_done,
    output logic              underflow
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int WPL = calc_wpl(FRAME_W);
    localparam int WPR = calc_wpr(BLK_W);
    localparam int WPB = calc_wpb(BLK_W, BLK_H);
    localparam int BX  = FRAME_W / BLK_W;
    localparam int BY  = FRAME_H / BLK_H;

    localparam int CW  = cnt_w(WPR);
    localparam int RW  = cnt_w(BLK_H);
    localparam int XW  = cnt_w(BX);
    localparam int YW  = cnt_w(BY);
    localparam int DW  = cnt_w(WPB);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int IFW = $clog2(MEM_LAT + 1);

    localparam logic [CW-1:0]     COL_MAX = CW'(WPR - 1);
    localparam logic [RW-1:0]     ROW_MAX = RW'(BLK_H - 1);
    localparam logic [XW-1:0]     BX_MAX  = XW'(BX - 1);
    localparam logic [YW-1:0]     BY_MAX  = YW'(BY - 1);
    localparam logic [DW-1:0]     DW_MAX  = DW'(WPB - 1);
    localparam logic [ADDR_W-1:0] WPL_A   = ADDR_W'(WPL);
    localparam logic [ADDR_W-1:0] WPR_A   = ADDR_W'(WPR);
    localparam logic [FCW:0]      OCC_LIM = (FCW + 1)'(FIFO_DEPTH);

    state_t state, state_nxt;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [XW-1:0]     bx;
    logic [YW-1:0]     by;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] blk_base;

    logic [MEM_LAT-1:0] vld_sr;
    logic [IFW-1:0]     in_flight;
    logic [FCW:0]       occ;

    logic [31:0]    fifo_head;
    logic [FCW-1:0] fifo_count;
    logic           fifo_empty;

    logic [DW-1:0] dw;
    logic [XW-1:0] dbx;
    logic [YW-1:0] dby;

    logic frame_start, last_issue, pop, starve, last_in_blk, last_deliver;

    assign frame_start  = (state == IDLE) && start;
    assign busy         = (state != IDLE);
    assign last_issue   = (col == COL_MAX) && (row == ROW_MAX) && (bx == BX_MAX) && (by == BY_MAX);
    assign pop          = req && busy && !fifo_empty;
    assign starve       = req && busy && fifo_empty;
    assign last_in_blk  = (dw == DW_MAX);
    assign last_deliver = last_in_blk && (dbx == BX_MAX) && (dby == BY_MAX);

    // Reads already issued but not yet in the FIFO, including the one landing this cycle.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < MEM_LAT; i++) in_flight = in_flight + IFW'(vld_sr[i]);
    end

    assign occ    = {1'b0, fifo_count} + (FCW + 1)'(in_flight);
    assign mem_rd = (state == FETCH) && (occ < OCC_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (mem_rd && last_issue) state_nxt = DRAIN;
            DRAIN:   if (pop && last_deliver) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address walk: +1 within a block row, +WPL per row, +WPR per block; past the
    // rightmost block, the word after its last row is the next block row's origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            bx       <= '0;
            by       <= '0;
            row_base <= '0;
            blk_base <= '0;
            mem_addr <= '0;
        end else if (frame_start) begin
            col      <= '0;
            row      <= '0;
            bx       <= '0;
            by       <= '0;
            row_base <= '0;
            blk_base <= '0;
            mem_addr <= '0;
        end else if (mem_rd) begin
            if (col != COL_MAX) begin
                col      <= col + 1'b1;
                mem_addr <= mem_addr + 1'b1;
            end else begin
                col <= '0;
                if (row != ROW_MAX) begin
                    row      <= row + 1'b1;
                    row_base <= row_base + WPL_A;
                    mem_addr <= row_base + WPL_A;
                end else begin
                    row <= '0;
                    if (bx != BX_MAX) begin
                        bx       <= bx + 1'b1;
                        blk_base <= blk_base + WPR_A;
                        row_base <= blk_base + WPR_A;
                        mem_addr <= blk_base + WPR_A;
                    end else begin
                        bx       <= '0;
                        by       <= (by == BY_MAX) ? '0 : by + 1'b1;
                        blk_base <= row_base + WPR_A;
                        row_base <= row_base + WPR_A;
                        mem_addr <= row_base + WPR_A;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= (vld_sr << 1) | MEM_LAT'(mem_rd);
    end

    cur_feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_sr[MEM_LAT-1]),
        .din   (mem_rdata),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            block_done <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            dw         <= '0;
            dbx        <= '0;
            dby        <= '0;
        end else begin
            block_done <= pop && last_in_blk;
            frame_done <= pop && last_deliver;
            if (starve) underflow <= 1'b1;
            if (pop) dout <= fifo_head;
            if (frame_start) begin
                dw  <= '0;
                dbx <= '0;
                dby <= '0;
            end else if (pop) begin
                if (!last_in_blk) begin
                    dw <= dw + 1'b1;
                end else begin
                    dw <= '0;
                    if (dbx != BX_MAX) begin
                        dbx <= dbx + 1'b1;
                    end else begin
                        dbx <= '0;
                        dby <= (dby == BY_MAX) ? '0 : dby + 1'b1;
                    end
                end
            end
        end
    end

`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                underflow_cnt <= '0;
        else if (starve && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cur_feeder.sv
// Bench for cur_feeder: two small-frame instances (short/long memory latency) checked against a block-raster reference list.
module tb_cur_feeder;

    localparam int FW = 16, FH = 16, BW = 8, BH = 8, AW = 8;
    localparam int LAT_A = 2, DEP_A = 4, LAT_B = 4, DEP_B = 8;
    localparam int NWORDS = (FW / 4) * FH;
    localparam int WPB_M  = (BW / 4) * BH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, req_a = 1'b0, start_b = 1'b0, req_b = 1'b0;
    logic [31:0]   dout_a, dout_b, rdata_a, rdata_b;
    logic          mem_rd_a, mem_rd_b, busy_a, busy_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          bd_a, bd_b, fd_a, fd_b, uf_a, uf_b;
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0]   ufc_a, ufc_b;
`endif

    cur_feeder #(.FRAME_W(FW), .FRAME_H(FH), .BLK_W(BW), .BLK_H(BH), .ADDR_W(AW),
                 .MEM_LAT(LAT_A), .FIFO_DEPTH(DEP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .req(req_a), .dout(dout_a),
        .mem_rd(mem_rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a), .busy(busy_a),
        .block_done(bd_a), .frame_done(fd_a), .underflow(uf_a)
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
        , .underflow_cnt(ufc_a)
`endif
    );

    cur_feeder #(.FRAME_W(FW), .FRAME_H(FH), .BLK_W(BW), .BLK_H(BH), .ADDR_W(AW),
                 .MEM_LAT(LAT_B), .FIFO_DEPTH(DEP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .req(req_b), .dout(dout_b),
        .mem_rd(mem_rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b), .busy(busy_b),
        .block_done(bd_b), .frame_done(fd_b), .underflow(uf_b)
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
        , .underflow_cnt(ufc_b)
`endif
    );

    // Frame memory: data = address, valid exactly MEM_LAT cycles after the read; junk otherwise.
    logic [31:0] pd_a [LAT_A];
    logic        pv_a [LAT_A];
    logic [31:0] pd_b [LAT_B];
    logic        pv_b [LAT_B];
    logic [31:0] junk = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        for (int i = LAT_A - 1; i > 0; i--) begin pd_a[i] <= pd_a[i-1]; pv_a[i] <= pv_a[i-1]; end
        for (int j = LAT_B - 1; j > 0; j--) begin pd_b[j] <= pd_b[j-1]; pv_b[j] <= pv_b[j-1]; end
        pd_a[0] <= {24'h0, addr_a};
        pv_a[0] <= mem_rd_a;
        pd_b[0] <= {24'h0, addr_b};
        pv_b[0] <= mem_rd_b;
        junk    <= $urandom;
    end
    assign rdata_a = pv_a[LAT_A-1] ? pd_a[LAT_A-1] : junk;
    assign rdata_b = pv_b[LAT_B-1] ? pd_b[LAT_B-1] : junk;

    // Issue monitor for instance A: address log and worst-case reads outstanding vs. words taken.
    logic clr_mon = 1'b0;
    int   issued_a, popped_a, max_occ_a;
    int   addr_log_a [$];
    always @(posedge clk) begin
        if (clr_mon) begin
            issued_a = 0; popped_a = 0; max_occ_a = 0;
            addr_log_a.delete();
        end else begin
            if (mem_rd_a) begin issued_a++; addr_log_a.push_back(int'(addr_a)); end
            if (req_a && busy_a) popped_a++;
            if (issued_a - popped_a > max_occ_a) max_occ_a = issued_a - popped_a;
        end
    end

    int checks = 0, errors = 0;
    int exp_q [$];
    logic [31:0] dlog [NWORDS];
    logic        bdlog [NWORDS];
    logic        fdlog [NWORDS];

    task automatic build_model;
        exp_q.delete();
        for (int by = 0; by < FH / BH; by++)
            for (int bx = 0; bx < FW / BW; bx++)
                for (int r = 0; r < BH; r++)
                    for (int c = 0; c < BW / 4; c++)
                        exp_q.push_back((by * BH + r) * (FW / 4) + bx * (BW / 4) + c);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // mode 0: req always high; 1: 2 high / 3 low; 2: always high plus a stray start mid-frame.
    task automatic drive_a(input int mode, output int got_n);
        int n;
        bit r;
        n = 0;
        start_a = 1'b1; clr_mon = 1'b1;
        step();
        start_a = 1'b0; clr_mon = 1'b0;
        repeat (8) step();
        for (int cyc = 0; cyc < 2000 && n < NWORDS; cyc++) begin
            r = (mode == 1) ? ((cyc % 5) < 2) : 1'b1;
            req_a = r;
            if (mode == 2 && cyc == 20) start_a = 1'b1;
            step();
            start_a = 1'b0;
            if (r) begin dlog[n] = dout_a; bdlog[n] = bd_a; fdlog[n] = fd_a; n++; end
        end
        req_a = 1'b0;
        repeat (3) step();
        got_n = n;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({dout_a, mem_rd_a, addr_a, busy_a, bd_a, fd_a, uf_a} !== '0) begin
            errors++; $display("FAIL reset_a got dout=%h rd=%b addr=%h busy=%b bd=%b fd=%b uf=%b exp all 0",
                               dout_a, mem_rd_a, addr_a, busy_a, bd_a, fd_a, uf_a);
        end
        checks++;
        if ({dout_b, mem_rd_b, addr_b, busy_b, bd_b, fd_b, uf_b} !== '0) begin
            errors++; $display("FAIL reset_b got dout=%h rd=%b addr=%h busy=%b exp all 0", dout_b, mem_rd_b, addr_b, busy_b);
        end
        rst_n = 1'b1;
        req_a = 1'b1; req_b = 1'b1;
        repeat (2) step();
        req_a = 1'b0; req_b = 1'b0;
        checks++;
        if ({busy_a, mem_rd_a, uf_a, uf_b} !== 4'b0) begin
            errors++; $display("FAIL idle_req got busy=%b rd=%b uf_a=%b uf_b=%b exp 0", busy_a, mem_rd_a, uf_a, uf_b);
        end
    endtask

    task automatic test_continuous;
        int n;
        drive_a(0, n);
        checks++;
        if (n !== NWORDS) begin errors++; $display("FAIL cont_count got %0d exp %0d", n, NWORDS); end
        for (int k = 0; k < NWORDS; k++) begin
            checks++;
            if (dlog[k] !== 32'(exp_q[k])) begin errors++; $display("FAIL cont_word[%0d] got %0d exp %0d", k, dlog[k], exp_q[k]); end
            checks++;
            if (bdlog[k] !== ((k % WPB_M) == WPB_M - 1)) begin errors++; $display("FAIL cont_bd[%0d] got %b", k, bdlog[k]); end
            checks++;
            if (fdlog[k] !== (k == NWORDS - 1)) begin errors++; $display("FAIL cont_fd[%0d] got %b", k, fdlog[k]); end
        end
        checks++;
        if (addr_log_a.size() !== NWORDS) begin errors++; $display("FAIL cont_issued got %0d exp %0d", addr_log_a.size(), NWORDS); end
        for (int k = 0; k < addr_log_a.size() && k < NWORDS; k++) begin
            checks++;
            if (addr_log_a[k] !== exp_q[k]) begin errors++; $display("FAIL cont_addr[%0d] got %0d exp %0d", k, addr_log_a[k], exp_q[k]); end
        end
        checks++;
        if ({busy_a, uf_a} !== 2'b00) begin errors++; $display("FAIL cont_end got busy=%b uf=%b exp 0 0", busy_a, uf_a); end
        checks++;
        if (max_occ_a > DEP_A) begin errors++; $display("FAIL cont_occ got %0d exp <= %0d", max_occ_a, DEP_A); end
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
        checks++;
        if (ufc_a !== 16'd0) begin errors++; $display("FAIL cont_ufc got %0d exp 0", ufc_a); end
`endif
    endtask

    task automatic test_block_wrap;
        checks++;
        if (dlog[16] !== 32'd2)  begin errors++; $display("FAIL wrap_blk1 got %0d exp 2", dlog[16]); end
        checks++;
        if (dlog[32] !== 32'd32) begin errors++; $display("FAIL wrap_blk2 got %0d exp 32", dlog[32]); end
        checks++;
        if (dlog[48] !== 32'd34) begin errors++; $display("FAIL wrap_blk3 got %0d exp 34", dlog[48]); end
        checks++;
        if (dlog[63] !== 32'd63) begin errors++; $display("FAIL wrap_last got %0d exp 63", dlog[63]); end
    endtask

    task automatic test_throttled;
        int n;
        drive_a(1, n);
        checks++;
        if (n !== NWORDS) begin errors++; $display("FAIL thr_count got %0d exp %0d", n, NWORDS); end
        for (int k = 0; k < NWORDS; k++) begin
            checks++;
            if (dlog[k] !== 32'(exp_q[k])) begin errors++; $display("FAIL thr_word[%0d] got %0d exp %0d", k, dlog[k], exp_q[k]); end
        end
        checks++;
        if (max_occ_a !== DEP_A) begin errors++; $display("FAIL thr_occ got %0d exp %0d", max_occ_a, DEP_A); end
        checks++;
        if ({fdlog[NWORDS-1], bdlog[NWORDS-1], uf_a} !== 3'b110) begin
            errors++; $display("FAIL thr_end got fd=%b bd=%b uf=%b exp 1 1 0", fdlog[NWORDS-1], bdlog[NWORDS-1], uf_a);
        end
    endtask

    task automatic test_start_ignored;
        int n;
        drive_a(2, n);
        checks++;
        if (addr_log_a.size() !== NWORDS) begin errors++; $display("FAIL stray_issued got %0d exp %0d", addr_log_a.size(), NWORDS); end
        for (int k = 0; k < NWORDS; k++) begin
            checks++;
            if (dlog[k] !== 32'(exp_q[k])) begin errors++; $display("FAIL stray_word[%0d] got %0d exp %0d", k, dlog[k], exp_q[k]); end
        end
        checks++;
        if ({fdlog[NWORDS-1], busy_a} !== 2'b10) begin errors++; $display("FAIL stray_end got fd=%b busy=%b exp 1 0", fdlog[NWORDS-1], busy_a); end
    endtask

    // Instance B: 3 requests before the first read can possibly return, then random req pacing.
    task automatic test_underflow_random;
        int n, nuf;
        bit r;
        n = 0; nuf = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_b = 1'b1;
            step();
            nuf++;
            checks++;
            if ({uf_b, dout_b} !== {1'b1, 32'd0}) begin errors++; $display("FAIL uf_flag[%0d] got uf=%b dout=%0d exp 1 0", i, uf_b, dout_b); end
        end
        req_b = 1'b0;
        repeat (10) step();
        for (int cyc = 0; cyc < 3000 && n < NWORDS; cyc++) begin
            r = ($urandom_range(0, 3) != 0);
            req_b = r;
            step();
            if (r) begin dlog[n] = dout_b; bdlog[n] = bd_b; fdlog[n] = fd_b; n++; end
        end
        req_b = 1'b0;
        repeat (3) step();
        checks++;
        if (n !== NWORDS) begin errors++; $display("FAIL uf_count got %0d exp %0d", n, NWORDS); end
        for (int k = 0; k < NWORDS; k++) begin
            checks++;
            if (dlog[k] !== 32'(exp_q[k])) begin errors++; $display("FAIL uf_word[%0d] got %0d exp %0d", k, dlog[k], exp_q[k]); end
            checks++;
            if ({bdlog[k], fdlog[k]} !== {((k % WPB_M) == WPB_M - 1), (k == NWORDS - 1)}) begin
                errors++; $display("FAIL uf_pulses[%0d] got bd=%b fd=%b", k, bdlog[k], fdlog[k]);
            end
        end
        checks++;
        if ({uf_b, busy_b} !== 2'b10) begin errors++; $display("FAIL uf_end got uf=%b busy=%b exp 1 0", uf_b, busy_b); end
`ifdef CUR_FEEDER_UNDERFLOW_CNT_EN
        checks++;
        if (ufc_b !== 16'(nuf)) begin errors++; $display("FAIL uf_cnt got %0d exp %0d", ufc_b, nuf); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        start_a = 1'b1; clr_mon = 1'b1;
        step();
        start_a = 1'b0; clr_mon = 1'b0;
        repeat (6) step();
        req_a = 1'b1;
        repeat (20) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_a, mem_rd_a, addr_a, busy_a, bd_a, fd_a} !== '0) begin
            errors++; $display("FAIL midrst got dout=%0d rd=%b addr=%0d busy=%b exp all 0", dout_a, mem_rd_a, addr_a, busy_a);
        end
        req_a = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy_a, mem_rd_a, addr_a} !== '0) begin errors++; $display("FAIL midrst_rel got busy=%b rd=%b addr=%0d exp 0", busy_a, mem_rd_a, addr_a); end
        drive_a(0, n);
        checks++;
        if (addr_log_a.size() < 1 || addr_log_a[0] !== 0) begin errors++; $display("FAIL midrst_first_addr got %0d entries exp first addr 0", addr_log_a.size()); end
        for (int k = 0; k < NWORDS; k++) begin
            checks++;
            if (dlog[k] !== 32'(exp_q[k])) begin errors++; $display("FAIL midrst_word[%0d] got %0d exp %0d", k, dlog[k], exp_q[k]); end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_continuous();
        test_block_wrap();
        test_throttled();
        test_start_ignored();
        test_underflow_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors so far", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/cur_feeder.md
Name: cur_feeder

Overview:
- Source side of the current-block load path. Fetches current-frame pixels from frame memory block by block, in raster order of blocks.
- Delivers one 32-bit word (4 x 8-bit pixels) per request on the request/data interface that the current-block buffer drives (en_in request, 32-bit in data).
- Hides frame-memory read latency with a small prefetch FIFO. Flags underflow when a request cannot be served.

Parameters:
- FRAME_W, 3840, frame width in pixels (multiple of BLK_W)
- FRAME_H, 2160, frame height in pixels (multiple of BLK_H)
- BLK_W, 8, block width in pixels (multiple of 4)
- BLK_H, 8, block height in pixels
- ADDR_W, 21, frame-memory word address width
- MEM_LAT, 2, frame-memory read latency in cycles (>=1)
- FIFO_DEPTH, 4, prefetch FIFO depth (power of 2, >= MEM_LAT+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse: begin a new frame at block (0,0)
- req  in  1  word request from the buffer (its en_in output)
- dout  out  32  requested word (to the buffer's in)
- mem_rd  out  1  frame-memory read strobe
- mem_addr  out  ADDR_W  frame-memory word address
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_rd
- busy  out  1  frame in progress
- block_done  out  1  one-cycle pulse when the last word of a block is delivered
- frame_done  out  1  one-cycle pulse when the last word of the frame is delivered
- underflow  out  1  sticky: a request arrived with the FIFO empty

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Outputs at reset: dout=0, mem_rd=0, mem_addr=0, busy=0, block_done=0, frame_done=0, underflow=0.
- FIFO, in-flight shift register and all counters clear at reset.
- Derived constants:
  - WPL = FRAME_W/4 (words per line)
  - WPR = BLK_W/4 (words per block row)
  - WPB = WPR*BLK_H (words per block)
  - BX = FRAME_W/BLK_W, BY = FRAME_H/BLK_H
  - Defaults give WPL=960, WPB=16, 480x270 blocks.
- Word order inside a block: row-major. Address = (by*BLK_H + r)*WPL + bx*WPR + c.
  - Generated incrementally: column counter, row_base += WPL per row, blk_base += WPR per block.
  - At bx = BX-1, blk_base jumps to the start of the next block row.
  - No multipliers.
- State machine:
  - IDLE: start -> FETCH, set busy, clear issue/deliver counters. underflow is not cleared.
  - FETCH: issue reads; after the last address of the frame is issued -> DRAIN.
  - DRAIN: no new reads; after the last word is delivered, pulse frame_done -> IDLE and clear busy.
  - start outside IDLE is ignored.
- Issue rule: mem_rd=1 in a cycle iff state=FETCH and (fifo_count + in_flight) < FIFO_DEPTH. This guarantees the FIFO never overflows.
  - mem_addr is registered together with mem_rd.
  - A MEM_LAT-deep valid shift register tracks in-flight reads; a returning valid pushes mem_rdata into the FIFO.
- Delivery (one-cycle latency):
  - req high in cycle n with FIFO non-empty: FIFO head pops and dout takes it at the end of cycle n, so it is valid through cycle n+1.
  - req low: dout holds.
- Underflow:
  - req high with FIFO empty while busy: underflow is set, dout holds its previous value, no pop, and the deliver counter does not advance.
  - req while IDLE is ignored and does not set underflow.
- Push and pop in the same cycle: fifo_count unchanged. Pop of the last entry and a push in the same cycle are legal.
- block_done / frame_done assert in the cycle after the delivering req, aligned with dout. On the last word of the frame both assert together.
- The deliver counter wraps per block at WPB. Block x/y counters wrap at BX and BY.

Optional Feature:
- CUR_FEEDER_UNDERFLOW_CNT_EN
- Defined: adds output underflow_cnt[15:0]. It increments once per underflowing request, saturates at 16'hFFFF, and clears only on reset.
- Undefined: port and counter absent. The sticky underflow flag alone remains.

Decomposition:
- Shared package cur_feeder_pkg: state enum (IDLE/FETCH/DRAIN), and functions computing WPL, WPR, WPB and frame word count from the parameters.
- One natural sub-module: cur_feeder_fifo (synchronous FIFO, FIFO_DEPTH x 32, count output, push/pop same cycle).
- Address generator and FSM stay in the top module.

Test Plan:
- Small-frame pass (FRAME_W=16, FRAME_H=16, BLK_W=8, BLK_H=8; memory returns data=address), start, then req held high -> dout sequence 0,1,4,5,8,9,...,29 for block (0,0); block_done every 16 words; frame_done after word 64; underflow stays 0.
- Block wrap, same frame -> block 1 begins at address 2, block 2 at 32, block 3 at 34, last word 63.
- Throttled req (2 high, 3 low, repeating) -> mem_rd stalls with fifo_count + in_flight = 4; no data loss; dout order identical to the continuous run.
- Underflow with MEM_LAT=4, FIFO_DEPTH=8, req asserted the cycle after start -> underflow=1, dout stays 0, first word later still delivered as 0; with CUR_FEEDER_UNDERFLOW_CNT_EN, count equals the number of empty-FIFO requests.
- start pulsed mid-frame -> ignored, address sequence unchanged; rst_n low mid-frame -> all outputs 0 immediately, busy=0, next start restarts at address 0.
